ex_operand_stage: RTL and testbench

- ID/EX pipeline stage sitting directly upstream of the ALU.
- Captures decoded operands and the 6-bit funct code from decode.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Presents registered in1/in2/opcode to the ALU under a valid/ready handshake, with stall and flush support.

---
 rtl/ex_operand_stage.sv | 153 +++++++++++++++
 tb/tb_ex_operand_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: single-entry valid/ready register feeding the ALU.
// Define EX_OPERAND_FWD_EN to enable MEM/WB forwarding, stall refresh and fwd_count.
module ex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [RADDR-1:0] id_rs_addr,
    input  logic [RADDR-1:0] id_rt_addr,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [5:0]       id_funct,
    input  logic [RADDR-1:0] id_rd_addr,
    input  logic             id_reg_write,
    input  logic             flush,
    input  logic             mem_reg_write,
    input  logic [RADDR-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_reg_write,
    input  logic [RADDR-1:0] wb_rd_addr,
    input  logic [WIDTH-1:0] wb_result,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [5:0]       alu_opcode,
    output logic [RADDR-1:0] ex_rd_addr,
    output logic             ex_reg_write,
    output logic [15:0]      fwd_count
);

    logic             r_valid;
    logic [WIDTH-1:0] r_in1;
    logic [WIDTH-1:0] r_in2;
    logic [5:0]       r_opcode;
    logic [RADDR-1:0] r_rd_addr;
    logic             r_reg_write;

    logic             w_accept;
    logic             w_transfer;
    logic [WIDTH-1:0] w_in1_next;
    logic [WIDTH-1:0] w_in2_next;

    assign id_ready   = !r_valid || ex_ready;
    assign w_accept   = id_valid && id_ready;
    assign w_transfer = r_valid && ex_ready;

`ifdef EX_OPERAND_FWD_EN
    // Returns {hit, value}; register 0 is never forwarded and MEM beats WB.
    function automatic logic [WIDTH:0] fwd_pick(
        input logic [RADDR-1:0] src,
        input logic [WIDTH-1:0] raw,
        input logic             m_we,
        input logic [RADDR-1:0] m_rd,
        input logic [WIDTH-1:0] m_res,
        input logic             w_we,
        input logic [RADDR-1:0] w_rd,
        input logic [WIDTH-1:0] w_res
    );
        if (src == '0)               return {1'b0, raw};
        if (m_we && (m_rd == src))   return {1'b1, m_res};
        if (w_we && (w_rd == src))   return {1'b1, w_res};
        return {1'b0, raw};
    endfunction

    logic [RADDR-1:0] r_rs_addr;
    logic [RADDR-1:0] r_rt_addr;
    logic [15:0]      r_fwd_count;
    logic [WIDTH:0]   w_cap_rs;
    logic [WIDTH:0]   w_cap_rt;
    logic [WIDTH:0]   w_ref_rs;
    logic [WIDTH:0]   w_ref_rt;
    logic [16:0]      w_cnt_sum;

    assign w_cap_rs = fwd_pick(id_rs_addr, id_rs_data, mem_reg_write, mem_rd_addr, mem_result,
                               wb_reg_write, wb_rd_addr, wb_result);
    assign w_cap_rt = fwd_pick(id_rt_addr, id_rt_data, mem_reg_write, mem_rd_addr, mem_result,
                               wb_reg_write, wb_rd_addr, wb_result);
    assign w_ref_rs = fwd_pick(r_rs_addr, r_in1, mem_reg_write, mem_rd_addr, mem_result,
                               wb_reg_write, wb_rd_addr, wb_result);
    assign w_ref_rt = fwd_pick(r_rt_addr, r_in2, mem_reg_write, mem_rd_addr, mem_result,
                               wb_reg_write, wb_rd_addr, wb_result);

    assign w_in1_next = w_cap_rs[WIDTH-1:0];
    assign w_in2_next = w_cap_rt[WIDTH-1:0];
    assign w_cnt_sum  = {1'b0, r_fwd_count} + 17'(w_cap_rs[WIDTH]) + 17'(w_cap_rt[WIDTH]);
    assign fwd_count  = r_fwd_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_fwd_count <= '0;
        end else if (!flush && w_accept) begin
            r_rs_addr   <= id_rs_addr;
            r_rt_addr   <= id_rt_addr;
            r_fwd_count <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        end
    end
`else
    // Forwarding disabled: the unused hazard inputs are folded into one sink net.
    logic w_unused_fwd;

    assign w_in1_next   = id_rs_data;
    assign w_in2_next   = id_rt_data;
    assign fwd_count    = '0;
    assign w_unused_fwd = ^{mem_reg_write, mem_rd_addr, mem_result,
                            wb_reg_write, wb_rd_addr, wb_result, id_rs_addr, id_rt_addr};
`endif

    // NOTE: all state updates use <= so every branch sees the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_in1       <= '0;
            r_in2       <= '0;
            r_opcode    <= '0;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_in1       <= w_in1_next;
            r_in2       <= w_in2_next;
            r_opcode    <= id_funct;
            r_rd_addr   <= id_rd_addr;
            r_reg_write <= id_reg_write;
        end else if (w_transfer) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end
`ifdef EX_OPERAND_FWD_EN
        else if (r_valid) begin
            // Stalled: pick up results that became available after capture.
            if (w_ref_rs[WIDTH]) r_in1 <= w_ref_rs[WIDTH-1:0];
            if (w_ref_rt[WIDTH]) r_in2 <= w_ref_rt[WIDTH-1:0];
        end
`endif
    end

    assign ex_valid     = r_valid;
    assign alu_in1      = r_in1;
    assign alu_in2      = r_in2;
    assign alu_opcode   = r_opcode;
    assign ex_rd_addr   = r_rd_addr;
    assign ex_reg_write = r_reg_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage; expectations follow EX_OPERAND_FWD_EN.
module tb_ex_operand_stage;

`ifdef EX_OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [31:0] id_rs_data, id_rt_data;
    logic [5:0]  id_funct;
    logic        id_reg_write;
    logic        flush;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_result;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] alu_in1, alu_in2;
    logic [5:0]  alu_opcode;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic [15:0] fwd_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.WIDTH(32), .RADDR(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_funct(id_funct), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .fwd_count(fwd_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [31:0] rsd,
                         input logic [4:0] rt, input logic [31:0] rtd,
                         input logic [5:0] fn, input logic [4:0] rd, input logic rw);
        id_valid     = 1'b1;
        id_rs_addr   = rs;
        id_rs_data   = rsd;
        id_rt_addr   = rt;
        id_rt_data   = rtd;
        id_funct     = fn;
        id_rd_addr   = rd;
        id_reg_write = rw;
    endtask

    task automatic set_fwd(input logic mw, input logic [4:0] ma, input logic [31:0] mr,
                           input logic ww, input logic [4:0] wa, input logic [31:0] wr);
        mem_reg_write = mw;
        mem_rd_addr   = ma;
        mem_result    = mr;
        wb_reg_write  = ww;
        wb_rd_addr    = wa;
        wb_result     = wr;
    endtask

    initial begin
        rst      = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        issue(5'd0, 32'd0, 5'd0, 32'd0, 6'd0, 5'd0, 1'b0);
        id_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #3;
        check("rst_valid", ex_valid, 0);
        check("rst_in1", alu_in1, 0);
        check("rst_in2", alu_in2, 0);
        check("rst_opcode", alu_opcode, 0);
        check("rst_regw", ex_reg_write, 0);
        check("rst_fwdcnt", fwd_count, 0);
        @(negedge clk);
        rst = 1'b1;

        // Plain add, no hazards
        issue(5'd3, 32'd10, 5'd4, 32'd5, 6'b100000, 5'd5, 1'b1);
        tick();
        check("add_valid", ex_valid, 1);
        check("add_in1", alu_in1, 10);
        check("add_in2", alu_in2, 5);
        check("add_op", alu_opcode, 6'b100000);
        check("add_rd", ex_rd_addr, 5);
        check("add_regw", ex_reg_write, 1);
        check("add_fwdcnt", fwd_count, 0);

        // MEM and WB both target r7: MEM wins
        issue(5'd7, 32'd1, 5'd4, 32'd5, 6'b100010, 5'd6, 1'b1);
        set_fwd(1'b1, 5'd7, 32'd99, 1'b1, 5'd7, 32'd55);
        tick();
        check("mem_valid", ex_valid, 1);
        check("mem_in1", alu_in1, FWD ? 32'd99 : 32'd1);
        check("mem_in2", alu_in2, 5);
        check("mem_op", alu_opcode, 6'b100010);
        check("mem_fwdcnt", fwd_count, FWD ? 1 : 0);

        // WB-only match on rt
        issue(5'd8, 32'd4, 5'd6, 32'd3, 6'b100000, 5'd1, 1'b1);
        set_fwd(1'b1, 5'd2, 32'd11, 1'b1, 5'd6, 32'd77);
        tick();
        check("wb_in1", alu_in1, 4);
        check("wb_in2", alu_in2, FWD ? 32'd77 : 32'd3);
        check("wb_fwdcnt", fwd_count, FWD ? 2 : 0);

        // Register 0 never forwarded; unsupported funct passes through
        issue(5'd0, 32'd0, 5'd0, 32'd0, 6'h3F, 5'd2, 1'b0);
        set_fwd(1'b1, 5'd0, 32'd123, 1'b1, 5'd0, 32'd456);
        tick();
        check("r0_in1", alu_in1, 0);
        check("r0_in2", alu_in2, 0);
        check("r0_op", alu_opcode, 6'h3F);
        check("r0_regw", ex_reg_write, 0);
        check("r0_fwdcnt", fwd_count, FWD ? 2 : 0);

        // Stall with WB refresh in the second stall cycle
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        issue(5'd1, 32'd11, 5'd9, 32'd2, 6'b100000, 5'd3, 1'b1);
        tick();
        check("st_cap_in2", alu_in2, 2);
        issue(5'd1, 32'hAA, 5'd9, 32'hBB, 6'b100010, 5'd4, 1'b1);
        ex_ready = 1'b0;
        #1;
        check("st_ready0", id_ready, 0);
        tick();
        check("st1_in2", alu_in2, 2);
        check("st1_ready", id_ready, 0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'd42);
        tick();
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("st2_in2", alu_in2, FWD ? 32'd42 : 32'd2);
        check("st2_ready", id_ready, 0);
        tick();
        check("st3_in2", alu_in2, FWD ? 32'd42 : 32'd2);
        check("st3_in1", alu_in1, 11);
        check("st3_op", alu_opcode, 6'b100000);
        check("st3_rd", ex_rd_addr, 3);
        check("st3_valid", ex_valid, 1);
        check("st3_fwdcnt", fwd_count, FWD ? 2 : 0);

        // Drain: transfer without a new accept
        id_valid = 1'b0;
        ex_ready = 1'b1;
        #1;
        check("dr_ready", id_ready, 1);
        tick();
        check("dr_valid", ex_valid, 0);
        check("dr_regw", ex_reg_write, 0);

        // Flush mid-stall discards the incoming instruction
        issue(5'd2, 32'd20, 5'd3, 32'd21, 6'b100000, 5'd7, 1'b1);
        tick();
        check("fl_pre_valid", ex_valid, 1);
        ex_ready = 1'b0;
        flush    = 1'b1;
        issue(5'd2, 32'h55, 5'd3, 32'h66, 6'b100010, 5'd8, 1'b1);
        tick();
        check("fl_valid", ex_valid, 0);
        check("fl_regw", ex_reg_write, 0);
        flush    = 1'b0;
        id_valid = 1'b0;
        tick();
        check("fl_post_valid", ex_valid, 0);

        // Asynchronous reset between edges
        ex_ready = 1'b1;
        issue(5'd2, 32'd33, 5'd3, 32'd34, 6'b100000, 5'd9, 1'b1);
        tick();
        id_valid = 1'b0;
        check("ar_pre_in1", alu_in1, 33);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", ex_valid, 0);
        check("ar_in1", alu_in1, 0);
        check("ar_in2", alu_in2, 0);
        check("ar_rd", ex_rd_addr, 0);
        check("ar_fwdcnt", fwd_count, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("ar_post_valid", ex_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
